// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2
  } state_e;

  // Column drive indexed by column select: [0]=1110 ... [3]=0111.
  localparam logic [3:0][3:0] ColDrive = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Key codes indexed by {row, col}; [0] is row 0 / col 0.
  localparam logic [15:0][3:0] KeyTable = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } row_hit_t;

  // Flags exactly one low row bit and returns its index.
  function automatic row_hit_t row_decode(input logic [3:0] row);
    row_hit_t hit;
    hit = '{single: 1'b0, idx: 2'd0};
    case (row)
      4'b1110: hit = '{single: 1'b1, idx: 2'd0};
      4'b1101: hit = '{single: 1'b1, idx: 2'd1};
      4'b1011: hit = '{single: 1'b1, idx: 2'd2};
      4'b0111: hit = '{single: 1'b1, idx: 2'd3};
      default: hit = '{single: 1'b0, idx: 2'd0};
    endcase
    return hit;
  endfunction

  // Row pattern expected while only row idx is pulled low.
  function automatic logic [3:0] row_low_pattern(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running column window divider; tick_o is high in the last cycle of each window.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..SCAN_DIV-1 and wrap.
  always_comb begin
    cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    tick_o = (cnt_q == CntLast);
  end

  // Divider register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, one code per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  // Count value from which one more matching tick reaches DEBOUNCE_TICKS.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

  logic            tick;
  state_e          state_q, state_d;
  logic [1:0]      col_sel_q, col_sel_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CntW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [3:0]      col_q;
  logic [3:0]      sync1_q, sync2_q;
  row_hit_t        hit;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_i;
      sync2_q <= sync1_q;
    end
  end

  // Scan / debounce / hold decisions, taken only on the window tick.
  always_comb begin
    state_d     = state_q;
    col_sel_d   = col_sel_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    hit         = row_decode(sync2_q);

    if (tick) begin
      case (state_q)
        StScan: begin
          if (hit.single) begin
            row_idx_d = hit.idx;
            deb_cnt_d = CntW'(1);
            state_d   = StDebounce;
          end else begin
            col_sel_d = col_sel_q + 2'd1;
          end
        end
        StDebounce: begin
          if (sync2_q == row_low_pattern(row_idx_q)) begin
            if (deb_cnt_q >= CntLast) begin
              key_code_d  = KeyTable[{row_idx_q, col_sel_q}];
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              rel_cnt_d   = '0;
              state_d     = StHeld;
            end else begin
              deb_cnt_d = deb_cnt_q + CntW'(1);
            end
          end else begin
            deb_cnt_d = '0;
            col_sel_d = col_sel_q + 2'd1;
            state_d   = StScan;
          end
        end
        StHeld: begin
          if (&sync2_q) begin
            if (rel_cnt_q >= CntLast) begin
              key_held_d = 1'b0;
              rel_cnt_d  = '0;
              col_sel_d  = col_sel_q + 2'd1;
              state_d    = StScan;
            end else begin
              rel_cnt_d = rel_cnt_q + CntW'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // State and output registers; col is registered from the next column select.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StScan;
      col_sel_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_q       <= 4'b1110;
    end else begin
      state_q     <= state_d;
      col_sel_q   <= col_sel_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_q       <= ColDrive[col_sel_d];
    end
  end

  assign col_o       = col_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule
